if_id_stage: RTL and testbench
==============================

# if_id_stage

Pipeline register between instruction fetch and decode in the RV32I core. Each cycle it captures the fetched instruction word and its PC, tracks whether the captured slot holds a real instruction, and presents it to decode. It freezes on a decode-side stall and converts the slot into a NOP bubble on a control-flow redirect. It also generates the stall request that freezes the fetch PC counter.

## Interface
Parameters:
- NOP_INST, 32'h0000_0013, instruction word presented when the slot is empty (addi x0,x0,0).
- RESET_PC, 32'h0000_0000, value of pc_d after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- inst_f  input  32  instruction word from fetch, combinational from instmem.
- pc_f  input  32  PC of inst_f.
- stall_d  input  1  hazard unit request to hold decode (load-use).
- flush  input  1  taken branch, jal or jalr redirect; kills the fetched instruction.
- inst_d  output  32  registered instruction to decode.
- pc_d  output  32  registered PC of inst_d.
- pc4_d  output  32  registered pc_d + 4, used as the link value.
- valid_d  output  1  inst_d is a real instruction.
- stall_f  output  1  freeze request to the fetch PC counter.
- bubble_cnt  output  32  count of cycles with valid_d=0 (see Configuration).
- stall_cnt  output  32  count of held cycles (see Configuration).

## Operation
- The FSM has three states. The state is what the register currently holds.
  - EMPTY: bubble. valid_d=0 and inst_d=NOP_INST.
  - FULL: freshly captured instruction. valid_d=1.
  - HELD: valid instruction frozen by a stall. valid_d=1.
- Transitions are evaluated at each rising edge with reset=0, in priority order:
  1. flush=1 → EMPTY. Load inst_d=NOP_INST. pc_d and pc4_d take pc_f and pc_f+4. flush beats stall_d.
  2. stall_d=1, state FULL or HELD → HELD. All outputs hold.
  3. stall_d=1, state EMPTY → EMPTY. The bubble holds.
  4. Otherwise → FULL. Capture inst_f, pc_f and pc_f+4.
- stall_f = stall_d & ~flush, combinational. On a redirect, fetch must always move to the target.
- pc4_d arithmetic is 32-bit modulo 2^32. pc_f=32'hFFFF_FFFC gives pc4_d=32'h0000_0000. No alignment check is done; pc_f[1:0] passes through unchanged.
- inst_f is never decoded here. Illegal encodings pass through untouched.

## Timing
- Reset values: state EMPTY, inst_d=NOP_INST, pc_d=RESET_PC, pc4_d=RESET_PC+4, valid_d=0, counters 0. stall_f is combinational and does not depend on reset.
- Latency: inst_f/pc_f sampled at edge N appear on inst_d/pc_d after edge N. One cycle, fully registered, no combinational path from inputs to inst_d, pc_d, pc4_d or valid_d.
- First edge after reset deasserts: the instruction at RESET_PC is captured and valid_d rises.
- Reset asserted mid-stall or mid-flush takes priority over everything: next state is EMPTY with reset values.
- A stall lasting K cycles holds the same inst_d/pc_d for K+1 output cycles. Exactly one instruction is presented per release.

## Configuration
- Macro: IF_ID_PERF_EN.
- Defined: bubble_cnt increments every edge after which valid_d=0. stall_cnt increments every edge that takes the HELD transition (rule 2). Both saturate at 32'hFFFF_FFFF and clear on reset.
- Not defined: no counter flops are built. bubble_cnt and stall_cnt are tied to 32'h0.
- Functional outputs are identical in both builds.

## Test plan
- Reset then free-run: reset 2 cycles, pc_f=0,4,8 with inst_f=32'h00500093, 32'h00100113, 32'h002081B3.
  → First edge: valid_d=1, inst_d=32'h00500093, pc_d=0, pc4_d=4.
  → Following edges track pc 4 and 8.
- Stall hold: FULL with pc_d=8, stall_d=1 for 3 cycles.
  → inst_d/pc_d stay at 8 for 4 output cycles.
  → stall_f=1 for 3 cycles.
  → stall_cnt=3 with IF_ID_PERF_EN.
- Flush: pc_f=32'h10, flush=1 for one cycle.
  → valid_d=0, inst_d=32'h00000013, bubble_cnt+1.
  → Next edge captures the target instruction with valid_d=1.
- Flush and stall together: stall_d=1, flush=1.
  → stall_f=0, state EMPTY, inst_d=NOP.
  → Following stall-only cycles keep the bubble with valid_d=0.
- Wrap: pc_f=32'hFFFF_FFFC.
  → pc4_d=32'h0000_0000.
- Reset during HELD: reset=1 while stall_d=1.
  → valid_d=0, pc_d=RESET_PC, pc4_d=RESET_PC+4 and counters 0 after one edge.

Source files
------------

// File: rtl/if_id_stage.sv
// IF/ID pipeline register for the RV32I core: captures fetch, holds on stall, bubbles on flush.
// Optional performance counters are built when IF_ID_PERF_EN is defined.
module if_id_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_f,
  input  logic [31:0] pc_f,
  input  logic        stall_d,
  input  logic        flush,
  output logic [31:0] inst_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic        valid_d,
  output logic        stall_f,
  output logic [31:0] bubble_cnt,
  output logic [31:0] stall_cnt
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t state;

  // A redirect always lets fetch move to the target, even under a load-use stall.
  assign stall_f = stall_d & ~flush;

  // Slot state and payload; every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      inst_d  <= NOP_INST;
      pc_d    <= RESET_PC;
      pc4_d   <= RESET_PC + PC_STEP;
      valid_d <= 1'b0;
    end else if (flush) begin
      state   <= EMPTY;
      inst_d  <= NOP_INST;
      pc_d    <= pc_f;
      pc4_d   <= pc_f + PC_STEP;
      valid_d <= 1'b0;
    end else if (stall_d) begin
      state <= (state == EMPTY) ? EMPTY : HELD;
    end else begin
      state   <= FULL;
      inst_d  <= inst_f;
      pc_d    <= pc_f;
      pc4_d   <= pc_f + PC_STEP;
      valid_d <= 1'b1;
    end
  end

`ifdef IF_ID_PERF_EN
  logic bubble_inc;
  logic stall_inc;

  // Mirror the transition priority: bubble after flush or a held bubble, stall on HELD entry.
  assign bubble_inc = flush | (stall_d & (state == EMPTY));
  assign stall_inc  = ~flush & stall_d & (state != EMPTY);

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (bubble_inc && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + XLEN'(1);
      if (stall_inc && (stall_cnt != '1))   stall_cnt  <= stall_cnt + XLEN'(1);
    end
  end
`else
  assign bubble_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized run against a slot model.
module tb_if_id_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall_d, flush;
  logic [31:0] inst_f, pc_f;
  logic [31:0] inst_d, pc_d, pc4_d, bubble_cnt, stall_cnt;
  logic        valid_d, stall_f;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: the slot either holds an instruction or is a bubble.
  logic        m_valid;
  logic [31:0] m_inst, m_pc;
  longint      m_bub, m_stl;
  logic        sf_seen, sf_exp;

  if_id_stage dut (
    .clk(clk), .reset(reset), .inst_f(inst_f), .pc_f(pc_f),
    .stall_d(stall_d), .flush(flush), .inst_d(inst_d), .pc_d(pc_d),
    .pc4_d(pc4_d), .valid_d(valid_d), .stall_f(stall_f),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_bub();
`ifdef IF_ID_PERF_EN
    return (m_bub > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_bub[31:0];
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_stl();
`ifdef IF_ID_PERF_EN
    return (m_stl > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_stl[31:0];
`else
    return 32'h0;
`endif
  endfunction

  // Drive one cycle of inputs, sample stall_f before the edge, advance the model after it.
  task automatic tick(input logic r, input logic sd, input logic fl,
                      input logic [31:0] ins, input logic [31:0] pc);
    reset = r; stall_d = sd; flush = fl; inst_f = ins; pc_f = pc;
    #1;
    sf_seen = stall_f;
    sf_exp  = sd && !fl;
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b0; m_inst = NOP; m_pc = RST_PC; m_bub = 0; m_stl = 0;
    end else if (fl) begin
      m_valid = 1'b0; m_inst = NOP; m_pc = pc; m_bub++;
    end else if (sd) begin
      if (m_valid) m_stl++;
      else m_bub++;
    end else begin
      m_valid = 1'b1; m_inst = ins; m_pc = pc;
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h40);
    tick(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h44);
    n_tests++;
    if (valid_d !== 1'b0 || inst_d !== NOP || pc_d !== RST_PC || pc4_d !== RST_PC + 32'd4) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b inst=%h pc=%h pc4=%h, need 0 %h %h %h",
               valid_d, inst_d, pc_d, pc4_d, NOP, RST_PC, RST_PC + 32'd4);
    end
    n_tests++;
    if (bubble_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_counters: bubble=%0d stall=%0d, need 0 0", bubble_cnt, stall_cnt);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] prog [3];
    prog[0] = 32'h0050_0093; prog[1] = 32'h0010_0113; prog[2] = 32'h0020_81B3;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, prog[i], 32'(4 * i));
      n_tests++;
      if (valid_d !== 1'b1 || inst_d !== prog[i] || pc_d !== 32'(4 * i) || pc4_d !== 32'(4 * i + 4)) begin
        n_fail++;
        $display("FAIL free_run[%0d]: valid=%b inst=%h pc=%h pc4=%h, need 1 %h %h %h",
                 i, valid_d, inst_d, pc_d, pc4_d, prog[i], 32'(4 * i), 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_stall_hold();
    longint stl0 = m_stl;
    // Slot currently holds pc 8 from the free run.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 32'h1234_0000 + 32'(i), 32'h0C + 32'(4 * i));
      n_tests++;
      if (sf_seen !== 1'b1 || valid_d !== 1'b1 || inst_d !== 32'h0020_81B3 || pc_d !== 32'h8) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: stall_f=%b valid=%b inst=%h pc=%h, need 1 1 002081b3 00000008",
                 i, sf_seen, valid_d, inst_d, pc_d);
      end
    end
    n_tests++;
`ifdef IF_ID_PERF_EN
    if (stall_cnt !== 32'(stl0 + 3)) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d need %0d", stall_cnt, stl0 + 3);
    end
`else
    if (stall_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL stall_cnt_off: got %0d need 0 (stl0 %0d)", stall_cnt, stl0);
    end
`endif
    tick(1'b0, 1'b0, 1'b0, 32'h0030_0193, 32'h0C);
    n_tests++;
    if (sf_seen !== 1'b0 || valid_d !== 1'b1 || inst_d !== 32'h0030_0193 || pc_d !== 32'h0C) begin
      n_fail++;
      $display("FAIL stall_release: stall_f=%b valid=%b inst=%h pc=%h, need 0 1 00300193 0000000c",
               sf_seen, valid_d, inst_d, pc_d);
    end
  endtask

  task automatic test_flush();
    longint bub0 = m_bub;
    tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10);
    n_tests++;
    if (valid_d !== 1'b0 || inst_d !== 32'h0000_0013 || pc_d !== 32'h10 || pc4_d !== 32'h14) begin
      n_fail++;
      $display("FAIL flush_bubble: valid=%b inst=%h pc=%h pc4=%h, need 0 00000013 00000010 00000014",
               valid_d, inst_d, pc_d, pc4_d);
    end
    n_tests++;
`ifdef IF_ID_PERF_EN
    if (bubble_cnt !== 32'(bub0 + 1)) begin
      n_fail++;
      $display("FAIL flush_bubble_cnt: got %0d need %0d", bubble_cnt, bub0 + 1);
    end
`else
    if (bubble_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_bubble_cnt_off: got %0d need 0 (bub0 %0d)", bubble_cnt, bub0);
    end
`endif
    tick(1'b0, 1'b0, 1'b0, 32'h0000_0517, 32'h10);
    n_tests++;
    if (valid_d !== 1'b1 || inst_d !== 32'h0000_0517 || pc_d !== 32'h10) begin
      n_fail++;
      $display("FAIL flush_target: valid=%b inst=%h pc=%h, need 1 00000517 00000010",
               valid_d, inst_d, pc_d);
    end
  endtask

  task automatic test_flush_stall();
    tick(1'b0, 1'b1, 1'b1, 32'hABCD_0001, 32'h20);
    n_tests++;
    if (sf_seen !== 1'b0 || valid_d !== 1'b0 || inst_d !== NOP) begin
      n_fail++;
      $display("FAIL flush_stall: stall_f=%b valid=%b inst=%h, need 0 0 %h", sf_seen, valid_d, inst_d, NOP);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, 1'b0, 32'hABCD_0002, 32'h24);
      n_tests++;
      if (sf_seen !== 1'b1 || valid_d !== 1'b0 || inst_d !== NOP || bubble_cnt !== exp_bub()
          || stall_cnt !== exp_stl()) begin
        n_fail++;
        $display("FAIL bubble_hold[%0d]: stall_f=%b valid=%b inst=%h bub=%0d stl=%0d, need 1 0 %h %0d %0d",
                 i, sf_seen, valid_d, inst_d, bubble_cnt, stall_cnt, NOP, exp_bub(), exp_stl());
      end
    end
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b0, 1'b0, 32'h0000_006F, 32'hFFFF_FFFC);
    n_tests++;
    if (pc_d !== 32'hFFFF_FFFC || pc4_d !== 32'h0000_0000 || valid_d !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: pc=%h pc4=%h valid=%b, need fffffffc 00000000 1", pc_d, pc4_d, valid_d);
    end
    tick(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0103);
    n_tests++;
    if (inst_d !== 32'hFFFF_FFFF || pc_d !== 32'h0000_0103 || pc4_d !== 32'h0000_0107) begin
      n_fail++;
      $display("FAIL passthrough: inst=%h pc=%h pc4=%h, need ffffffff 00000103 00000107",
               inst_d, pc_d, pc4_d);
    end
  endtask

  task automatic test_reset_held();
    tick(1'b0, 1'b0, 1'b0, 32'h0000_0093, 32'h30);
    tick(1'b0, 1'b1, 1'b0, 32'h0000_0094, 32'h34);
    tick(1'b1, 1'b1, 1'b0, 32'h0000_0095, 32'h38);
    n_tests++;
    if (valid_d !== 1'b0 || inst_d !== NOP || pc_d !== RST_PC || pc4_d !== RST_PC + 32'd4
        || bubble_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_held: valid=%b inst=%h pc=%h pc4=%h bub=%0d stl=%0d, need 0 %h %h %h 0 0",
               valid_d, inst_d, pc_d, pc4_d, bubble_cnt, stall_cnt, NOP, RST_PC, RST_PC + 32'd4);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0050_0093, RST_PC);
    n_tests++;
    if (valid_d !== 1'b1 || inst_d !== 32'h0050_0093 || pc_d !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b inst=%h pc=%h, need 1 00500093 %h", valid_d, inst_d, pc_d, RST_PC);
    end
  endtask

  task automatic test_random();
    logic r, sd, fl;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      sd = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 5) == 0);
      tick(r, sd, fl, $urandom, $urandom);
      n_tests++;
      if (sf_seen !== sf_exp || valid_d !== m_valid || inst_d !== m_inst || pc_d !== m_pc
          || pc4_d !== m_pc + 32'd4 || bubble_cnt !== exp_bub() || stall_cnt !== exp_stl()) begin
        n_fail++;
        $display("FAIL random[%0d]: sf=%b v=%b i=%h pc=%h pc4=%h b=%0d s=%0d, need %b %b %h %h %h %0d %0d",
                 i, sf_seen, valid_d, inst_d, pc_d, pc4_d, bubble_cnt, stall_cnt,
                 sf_exp, m_valid, m_inst, m_pc, m_pc + 32'd4, exp_bub(), exp_stl());
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall_hold();
    test_flush();
    test_flush_stall();
    test_wrap();
    test_reset_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
